// File: rtl/fifo_wptr_full_if.sv
// Write-side bundle of an async FIFO: write request, synced read pointer,
// memory write port and the status flags derived in the write clock domain.
interface fifo_wptr_full_if #(
    parameter int ADDR_SIZE = 3
);
    logic                 winc;
    logic [ADDR_SIZE:0]   rq2_rptr;
    logic                 wen;
    logic [ADDR_SIZE-1:0] waddr;
    logic [ADDR_SIZE:0]   wptr;
    logic                 full;
    logic                 almost_full;
    logic [ADDR_SIZE:0]   wlevel;
    logic                 overflow;

    modport master (
        output winc, rq2_rptr,
        input  wen, waddr, wptr, full, almost_full, wlevel, overflow
    );

    modport slave (
        input  winc, rq2_rptr,
        output wen, waddr, wptr, full, almost_full, wlevel, overflow
    );
endinterface

// File: rtl/fifo_wptr_full.sv
// Async FIFO write-pointer and full logic: binary/Gray write pointer,
// registered full/almost_full/level flags and sticky overflow.
module fifo_wptr_full #(
    parameter int ADDR_SIZE = 3,
    parameter int AF_MARGIN = 1
) (
    input  logic             sclk,
    input  logic             srst,
    fifo_wptr_full_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] AF_TH = (ADDR_SIZE+1)'(DEPTH - AF_MARGIN);

    logic [ADDR_SIZE:0] wbin;
    logic [ADDR_SIZE:0] wbin_next;
    logic [ADDR_SIZE:0] wgray_next;
    logic [ADDR_SIZE:0] rbin_s;
    logic [ADDR_SIZE:0] level_next;
    logic [ADDR_SIZE:0] full_cmp;
    logic [ADDR_SIZE:0] wptr;
    logic [ADDR_SIZE:0] wlevel;
    logic               full;
    logic               almost_full;
    logic               overflow;
    logic               wen;

    assign wen        = bus.winc & ~full;
    assign wbin_next  = wbin + {{ADDR_SIZE{1'b0}}, wen};
    assign wgray_next = (wbin_next >> 1) ^ wbin_next;

    // Gray to binary: each bit is the XOR of itself and all bits above
    always_comb begin
        rbin_s = '0;
        for (int i = 0; i <= ADDR_SIZE; i++) begin
            rbin_s[i] = ^(bus.rq2_rptr >> i);
        end
    end

    assign level_next = wbin_next - rbin_s;
    assign full_cmp   = {~bus.rq2_rptr[ADDR_SIZE:ADDR_SIZE-1],
                         bus.rq2_rptr[ADDR_SIZE-2:0]};

    always_ff @(posedge sclk) begin
        if (srst) begin
            wbin        <= '0;
            wptr        <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wlevel      <= '0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wptr        <= wgray_next;
            full        <= (wgray_next == full_cmp);
            almost_full <= (level_next >= AF_TH);
            wlevel      <= level_next;
            if (bus.winc && full) begin
                overflow <= 1'b1;
            end
        end
    end

    assign bus.wen         = wen;
    assign bus.waddr       = wbin[ADDR_SIZE-1:0];
    assign bus.wptr        = wptr;
    assign bus.full        = full;
    assign bus.almost_full = almost_full;
    assign bus.wlevel      = wlevel;
    assign bus.overflow    = overflow;
endmodule
